controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port op, input, 6 bits: instr[31:26] from datapath.
REQ-004 The block SHALL have port funct, input, 6 bits: instr[5:0] from datapath.
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 The block SHALL have ports pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg and regdst, each an output of 1 bit: datapath/memory enables and mux selects.
REQ-007 The block SHALL have ports alusrcb and pcsrc, each an output of 2 bits: mux selects.
REQ-008 The block SHALL have port alucontrol, output, 3 bits: ALU operation.
REQ-009 The block SHALL have port state, output, 4 bits: current FSM state, for debug and verification.

Function
REQ-010 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, held in a 4-bit register.
REQ-011 Transitions SHALL be: FETCH->DECODE.
REQ-012 From DECODE, transitions SHALL be: op 100011 (lw) or 101011 (sw) ->MEMADR; 000000 ->RTYPEEX; 000100 ->BEQEX; 001000 ->ADDIEX; 000010 ->JEX; any other op ->FETCH.
REQ-013 From MEMADR, op 100011 SHALL go to MEMRD and any other op SHALL go to MEMWR; MEMRD->MEMWB.
REQ-014 MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX SHALL go to FETCH; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
REQ-015 Encodings 12-15 SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-016 Every output not listed for a state SHALL be 0.
REQ-017 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
REQ-018 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00.
REQ-019 MEMADR and ADDIEX SHALL drive alusrca=1, alusrcb=10, aluop=00.
REQ-020 MEMRD SHALL drive iord=1; MEMWR SHALL drive iord=1, memwrite=1.
REQ-021 MEMWB SHALL drive regdst=0, memtoreg=1, regwrite=1.
REQ-022 RTYPEEX SHALL drive alusrca=1, alusrcb=00, aluop=10; RTYPEWB SHALL drive regdst=1, memtoreg=0, regwrite=1.
REQ-023 BEQEX SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
REQ-024 ADDIWB SHALL drive regdst=0, memtoreg=0, regwrite=1.
REQ-025 JEX SHALL drive pcsrc=10, pcwrite=1.
REQ-026 pcen SHALL be combinational: pcwrite OR (branch AND zero); zero SHALL affect pcen only in BEQEX.
REQ-027 alucontrol SHALL be combinational from the internal 2-bit aluop and funct: aluop 00->010 (add); aluop 01->110 (sub); aluop 11->010 (add).
REQ-028 For aluop 10, funct SHALL map: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
REQ-029 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; illegal op 2 cycles (FETCH, DECODE).
REQ-030 The block SHALL contain no other state; op and funct SHALL be sampled combinationally, since the instruction register is stable after FETCH.

Reset
REQ-031 While reset=1 at a rising edge, state SHALL become FETCH, regardless of the current state, including mid-instruction.
REQ-032 After reset, outputs SHALL be the FETCH values: pcen=1, irwrite=1, alusrcb=01, alucontrol=010, all others 0.
REQ-033 Reset asserted in MEMWR SHALL return the block to FETCH; memwrite SHALL be 0 in the first cycle after that edge.

Verification
REQ-034 Reset, then op=100011 -> state 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
REQ-035 op=000000, funct=100010 -> state 0,1,6,7,0; alucontrol=110 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-036 op=000100, zero=1 in BEQEX -> pcen=1, pcsrc=01, alucontrol=110; repeat with zero=0 -> pcen=0; zero=1 in any other non-PC-write state -> pcen=0.
REQ-037 op=000010 -> state 0,1,11,0; pcen=1 and pcsrc=10 in state 11; op=101011 -> memwrite=1 for exactly one cycle, in state 5.
REQ-038 Illegal op=111111 -> DECODE->FETCH with no regwrite/memwrite pulse; reset asserted in state 3 -> state 0 next cycle.

Source files
------------

// File: rtl/controller.sv
// Multicycle MIPS-style control unit: Moore FSM with registered datapath
// controls, plus combinational PC enable and ALU operation decode.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   op, funct         - instr[31:26] and instr[5:0] from the datapath
//   zero              - ALU zero flag, used only for beq
//   pcen              - PC write enable (pcwrite | branch & zero)
//   irwrite, regwrite - instruction register / register file writes
//   memwrite          - data memory write strobe
//   alusrca, iord     - ALU A select, memory address select
//   memtoreg, regdst  - writeback data / destination selects
//   alusrcb, pcsrc    - ALU B select, next PC select
//   alucontrol        - ALU operation
//   state             - current FSM state, for debug
module controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   state_t     state_q, state_d;

   logic       pcwrite_q,  pcwrite_d;
   logic       branch_q,   branch_d;
   logic       irwrite_q,  irwrite_d;
   logic       regwrite_q, regwrite_d;
   logic       memwrite_q, memwrite_d;
   logic       alusrca_q,  alusrca_d;
   logic       iord_q,     iord_d;
   logic       memtoreg_q, memtoreg_d;
   logic       regdst_q,   regdst_d;
   logic [1:0] alusrcb_q,  alusrcb_d;
   logic [1:0] pcsrc_q,    pcsrc_d;
   logic [1:0] aluop_q,    aluop_d;

   // Next-state logic. op is read straight from the instruction register,
   // which holds steady from DECODE until the next FETCH.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH: state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW,
               OP_SW:    state_d = MEMADR;
               OP_RTYPE: state_d = RTYPEEX;
               OP_BEQ:   state_d = BEQEX;
               OP_ADDI:  state_d = ADDIEX;
               OP_J:     state_d = JEX;
               default:  state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = MEMWB;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   // Moore outputs are decoded from the state being entered and registered
   // alongside it, so they change on the same edge as state and are glitch
   // free while still matching the current state value.
   always_comb begin
      pcwrite_d  = 1'b0;
      branch_d   = 1'b0;
      irwrite_d  = 1'b0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      alusrca_d  = 1'b0;
      iord_d     = 1'b0;
      memtoreg_d = 1'b0;
      regdst_d   = 1'b0;
      alusrcb_d  = 2'b00;
      pcsrc_d    = 2'b00;
      aluop_d    = ALUOP_ADD;
      case (state_d)
         FETCH: begin
            alusrcb_d = 2'b01;
            irwrite_d = 1'b1;
            pcwrite_d = 1'b1;
         end
         DECODE: begin
            alusrcb_d = 2'b11;
         end
         MEMADR,
         ADDIEX: begin
            alusrca_d = 1'b1;
            alusrcb_d = 2'b10;
         end
         MEMRD: begin
            iord_d = 1'b1;
         end
         MEMWB: begin
            memtoreg_d = 1'b1;
            regwrite_d = 1'b1;
         end
         MEMWR: begin
            iord_d     = 1'b1;
            memwrite_d = 1'b1;
         end
         RTYPEEX: begin
            alusrca_d = 1'b1;
            aluop_d   = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            regdst_d   = 1'b1;
            regwrite_d = 1'b1;
         end
         BEQEX: begin
            alusrca_d = 1'b1;
            aluop_d   = ALUOP_SUB;
            pcsrc_d   = 2'b01;
            branch_d  = 1'b1;
         end
         ADDIWB: begin
            regwrite_d = 1'b1;
         end
         JEX: begin
            pcsrc_d   = 2'b10;
            pcwrite_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State and output registers. Reset lands in FETCH with FETCH controls,
   // which also clears any write strobe caught mid-instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         pcwrite_q  <= 1'b1;
         branch_q   <= 1'b0;
         irwrite_q  <= 1'b1;
         regwrite_q <= 1'b0;
         memwrite_q <= 1'b0;
         alusrca_q  <= 1'b0;
         iord_q     <= 1'b0;
         memtoreg_q <= 1'b0;
         regdst_q   <= 1'b0;
         alusrcb_q  <= 2'b01;
         pcsrc_q    <= 2'b00;
         aluop_q    <= ALUOP_ADD;
      end else begin
         state_q    <= state_d;
         pcwrite_q  <= pcwrite_d;
         branch_q   <= branch_d;
         irwrite_q  <= irwrite_d;
         regwrite_q <= regwrite_d;
         memwrite_q <= memwrite_d;
         alusrca_q  <= alusrca_d;
         iord_q     <= iord_d;
         memtoreg_q <= memtoreg_d;
         regdst_q   <= regdst_d;
         alusrcb_q  <= alusrcb_d;
         pcsrc_q    <= pcsrc_d;
         aluop_q    <= aluop_d;
      end
   end

   // ALU decode: funct only matters for R-type execute.
   always_comb begin
      alucontrol = 3'b010;
      case (aluop_q)
         ALUOP_ADD: alucontrol = 3'b010;
         ALUOP_SUB: alucontrol = 3'b110;
         ALUOP_FUNCT: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   // branch is only ever set in BEQEX, so zero is ignored elsewhere.
   assign pcen       = pcwrite_q | (branch_q & zero);
   assign irwrite    = irwrite_q;
   assign regwrite   = regwrite_q;
   assign memwrite   = memwrite_q;
   assign alusrca    = alusrca_q;
   assign iord       = iord_q;
   assign memtoreg   = memtoreg_q;
   assign regdst     = regdst_q;
   assign alusrcb    = alusrcb_q;
   assign pcsrc      = pcsrc_q;
   assign state      = state_q;

endmodule

// File: tb/tb_controller.sv
// Directed testbench for controller: walks every instruction class
// through its state sequence and checks the full output vector per cycle.
module tb_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, regwrite, memwrite;
  logic       alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  logic [18:0] obs;
  assign obs = {state, pcen, irwrite, regwrite, memwrite, alusrca,
                iord, memtoreg, regdst, alusrcb, pcsrc, alucontrol};

  localparam logic [18:0] E_FETCH  = 19'b0000_1_1_0_0_0_0_0_0_01_00_010;
  localparam logic [18:0] E_DEC    = 19'b0001_0_0_0_0_0_0_0_0_11_00_010;
  localparam logic [18:0] E_MADR   = 19'b0010_0_0_0_0_1_0_0_0_10_00_010;
  localparam logic [18:0] E_MRD    = 19'b0011_0_0_0_0_0_1_0_0_00_00_010;
  localparam logic [18:0] E_MWB    = 19'b0100_0_0_1_0_0_0_1_0_00_00_010;
  localparam logic [18:0] E_MWR    = 19'b0101_0_0_0_1_0_1_0_0_00_00_010;
  localparam logic [18:0] E_RWB    = 19'b0111_0_0_1_0_0_0_0_1_00_00_010;
  localparam logic [18:0] E_BEQ_T  = 19'b1000_1_0_0_0_1_0_0_0_00_01_110;
  localparam logic [18:0] E_BEQ_F  = 19'b1000_0_0_0_0_1_0_0_0_00_01_110;
  localparam logic [18:0] E_AEX    = 19'b1001_0_0_0_0_1_0_0_0_10_00_010;
  localparam logic [18:0] E_AWB    = 19'b1010_0_0_1_0_0_0_0_0_00_00_010;
  localparam logic [18:0] E_JEX    = 19'b1011_1_0_0_0_0_0_0_0_00_10_010;
  localparam logic [15:0] E_REX_HI = 16'b0110_0_0_0_0_1_0_0_0_00_00;

  controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== E_FETCH) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, E_FETCH);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [18:0] exp [0:5];
    exp = '{E_FETCH, E_DEC, E_MADR, E_MRD, E_MWB, E_FETCH};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL lw step %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_sw();
    logic [18:0] exp [0:4];
    exp = '{E_FETCH, E_DEC, E_MADR, E_MWR, E_FETCH};
    op   = 6'b101011;
    zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL sw step %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 4) tick();
    end
    zero = 1'b0;
  endtask

  task automatic test_rtype();
    logic [18:0] exp [0:4];
    exp = '{E_FETCH, E_DEC, {E_REX_HI, 3'b110}, E_RWB, E_FETCH};
    op    = 6'b000000;
    funct = 6'b100010;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL rtype step %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_funct();
    logic [5:0] fn  [0:4];
    logic [2:0] alu [0:4];
    logic [18:0] want;
    fn  = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    alu = '{3'b010, 3'b000, 3'b001, 3'b111, 3'b010};
    op  = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = fn[i];
      tick();
      tick();
      want = {E_REX_HI, alu[i]};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL funct %b: got %h want %h", fn[i], obs, want);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_beq();
    logic [18:0] exp [0:3];
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      exp = '{E_FETCH, E_DEC, (z == 1) ? E_BEQ_T : E_BEQ_F, E_FETCH};
      zero = (z == 1);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs !== exp[i]) begin
          errors++;
          $display("FAIL beq z=%0d step %0d: got %h want %h",
                   z, i, obs, exp[i]);
        end
        if (i < 3) tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    logic [18:0] exp [0:4];
    exp = '{E_FETCH, E_DEC, E_AEX, E_AWB, E_FETCH};
    op = 6'b001000;
    zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL addi step %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 4) tick();
    end
    zero = 1'b0;
  endtask

  task automatic test_j();
    logic [18:0] exp [0:3];
    exp = '{E_FETCH, E_DEC, E_JEX, E_FETCH};
    op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL j step %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_illegal();
    logic [18:0] exp [0:3];
    exp = '{E_FETCH, E_DEC, E_FETCH, E_DEC};
    op = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL illegal step %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 3) tick();
    end
    tick();
  endtask

  task automatic test_reset_mid();
    op = 6'b100011;
    tick();
    tick();
    tick();
    checks++;
    if (obs !== E_MRD) begin
      errors++;
      $display("FAIL rst_mrd pre: got %h want %h", obs, E_MRD);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== E_FETCH) begin
      errors++;
      $display("FAIL rst_mrd: got %h want %h", obs, E_FETCH);
    end
    op = 6'b101011;
    tick();
    tick();
    tick();
    checks++;
    if (obs !== E_MWR) begin
      errors++;
      $display("FAIL rst_mwr pre: got %h want %h", obs, E_MWR);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== E_FETCH) begin
      errors++;
      $display("FAIL rst_mwr: got %h want %h", obs, E_FETCH);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (checks > 0 && ^obs === 1'bx) begin
      errors++;
      $display("FAIL xcheck: got %h want no X", obs);
    end
  end

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_funct();
    test_beq();
    test_addi();
    test_j();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
